// File: rtl/uart_rx_deframer.sv
// Frame parser behind the UART RX FIFO: hunts SYNC, then DEST, LEN, PAYLOAD[LEN], CSUM.
// Payload is streamed on a valid/ready port and every frame ends with a status pulse.
module uart_rx_deframer #(
    parameter int         FIFO_CNT_W = 5,
    parameter logic [7:0] SYNC_BYTE  = 8'h7E,
    parameter int         MAX_LEN    = 64,
    parameter int         TIMEOUT    = 50000,
    parameter int         TO_W       = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [FIFO_CNT_W-1:0] rf_count,
    input  logic [7:0]            rdr,
    output logic                  rf_pop,
    output logic [7:0]            m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic                  m_last,
    output logic [7:0]            m_dest,
    output logic                  frame_done,
    output logic [1:0]            frame_err,
    output logic [7:0]            ok_cnt,
    output logic [7:0]            err_cnt
);

    typedef enum logic [2:0] {
        ST_HUNT    = 3'd0,
        ST_ADDR    = 3'd1,
        ST_LEN     = 3'd2,
        ST_PAYLOAD = 3'd3,
        ST_CSUM    = 3'd4
    } state_t;

    localparam logic [7:0]      MAX_LEN_B = 8'(MAX_LEN);
    // Firing two counts early lands frame_done exactly TIMEOUT cycles after the last pop.
    localparam logic [TO_W-1:0] TO_FIRE   = TO_W'(TIMEOUT - 2);
    localparam logic [1:0]      ERR_OK    = 2'b00;
    localparam logic [1:0]      ERR_CSUM  = 2'b01;
    localparam logic [1:0]      ERR_LEN   = 2'b10;
    localparam logic [1:0]      ERR_TO    = 2'b11;

    function automatic logic [7:0] sum8(input logic [7:0] a, input logic [7:0] b);
        return a + b;
    endfunction

    state_t          r_state;
    logic [7:0]      r_sum;
    logic [7:0]      r_rem;
    logic [TO_W-1:0] r_to_cnt;
    logic            r_pop_q;
    logic [7:0]      r_m_data;
    logic            r_m_valid;
    logic            r_m_last;
    logic [7:0]      r_m_dest;
    logic            r_frame_done;
    logic [1:0]      r_frame_err;
    logic [7:0]      r_ok_cnt;
    logic [7:0]      r_err_cnt;

    logic       w_fifo_nz;
    logic       w_out_free;
    logic       w_can_take;
    logic       w_fetch;
    logic       w_waiting;
    logic       w_to_hit;
    logic       w_len_bad;
    logic [7:0] w_sum_nxt;

    assign w_fifo_nz  = (rf_count != {FIFO_CNT_W{1'b0}});
    assign w_out_free = !r_m_valid || m_ready;
    assign w_fetch    = !rst && w_fifo_nz && !r_pop_q && w_can_take;
    assign w_waiting  = (r_state != ST_HUNT) && !w_fifo_nz && !(r_m_valid && !m_ready);
    assign w_to_hit   = w_waiting && (r_to_cnt >= TO_FIRE);
    assign w_len_bad  = (rdr == 8'd0) || (rdr > MAX_LEN_B);
    assign w_sum_nxt  = sum8(r_sum, rdr);

    // Per-state permission to take a byte from the FIFO
    always_comb begin
        w_can_take = 1'b0;
        case (r_state)
            ST_HUNT, ST_ADDR, ST_LEN, ST_CSUM: w_can_take = 1'b1;
            ST_PAYLOAD:                       w_can_take = (r_rem != 8'd0) && w_out_free;
            default:                          w_can_take = 1'b0;
        endcase
    end

    // Frame FSM, timeout counter, output register and status counters
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_HUNT;
            r_sum        <= 8'd0;
            r_rem        <= 8'd0;
            r_to_cnt     <= {TO_W{1'b0}};
            // Holding off the first fetch keeps rf_pop low in the cycle after reset.
            r_pop_q      <= 1'b1;
            r_m_data     <= 8'd0;
            r_m_valid    <= 1'b0;
            r_m_last     <= 1'b0;
            r_m_dest     <= 8'd0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 2'b00;
            r_ok_cnt     <= 8'd0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_pop_q      <= w_fetch;
            r_frame_done <= 1'b0;
            if (w_fetch) begin
                r_to_cnt <= {TO_W{1'b0}};
            end else if (w_waiting) begin
                r_to_cnt <= r_to_cnt + {{(TO_W-1){1'b0}}, 1'b1};
            end
            if (r_m_valid && m_ready) begin
                r_m_valid <= 1'b0;
                r_m_last  <= 1'b0;
            end
            if (w_to_hit) begin
                r_frame_done <= 1'b1;
                r_frame_err  <= ERR_TO;
                r_err_cnt    <= r_err_cnt + 8'd1;
                r_m_valid    <= 1'b0;
                r_m_last     <= 1'b0;
                r_to_cnt     <= {TO_W{1'b0}};
                r_state      <= ST_HUNT;
            end else begin
                case (r_state)
                    ST_HUNT: begin
                        if (w_fetch && (rdr == SYNC_BYTE)) begin
                            r_to_cnt <= {TO_W{1'b0}};
                            r_state  <= ST_ADDR;
                        end
                    end
                    ST_ADDR: begin
                        if (w_fetch) begin
                            r_m_dest <= rdr;
                            r_sum    <= rdr;
                            r_state  <= ST_LEN;
                        end
                    end
                    ST_LEN: begin
                        if (w_fetch) begin
                            if (w_len_bad) begin
                                r_frame_done <= 1'b1;
                                r_frame_err  <= ERR_LEN;
                                r_err_cnt    <= r_err_cnt + 8'd1;
                                r_state      <= ST_HUNT;
                            end else begin
                                r_rem   <= rdr;
                                r_sum   <= w_sum_nxt;
                                r_state <= ST_PAYLOAD;
                            end
                        end
                    end
                    ST_PAYLOAD: begin
                        if (w_fetch) begin
                            r_m_data  <= rdr;
                            r_m_valid <= 1'b1;
                            r_m_last  <= (r_rem == 8'd1);
                            r_rem     <= r_rem - 8'd1;
                            r_sum     <= w_sum_nxt;
                        end else if ((r_rem == 8'd0) && w_out_free) begin
                            r_state <= ST_CSUM;
                        end
                    end
                    ST_CSUM: begin
                        if (w_fetch) begin
                            r_frame_done <= 1'b1;
                            if (w_sum_nxt == 8'd0) begin
                                r_frame_err <= ERR_OK;
                                r_ok_cnt    <= r_ok_cnt + 8'd1;
                            end else begin
                                r_frame_err <= ERR_CSUM;
                                r_err_cnt   <= r_err_cnt + 8'd1;
                            end
                            r_state <= ST_HUNT;
                        end
                    end
                    default: r_state <= ST_HUNT;
                endcase
            end
        end
    end

    assign rf_pop     = w_fetch;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;
    assign m_last     = r_m_last;
    assign m_dest     = r_m_dest;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign ok_cnt     = r_ok_cnt;
    assign err_cnt    = r_err_cnt;

endmodule

// File: tb/tb_uart_rx_deframer.sv
// Directed bench for uart_rx_deframer: a queue models the UART RX FIFO and every
// observation is taken 1 time unit after the falling edge.
module tb_uart_rx_deframer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] rf_count = 5'd0;
    logic [7:0] rdr = 8'd0;
    logic       rf_pop;
    logic [7:0] m_data;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_last;
    logic [7:0] m_dest;
    logic       frame_done;
    logic [1:0] frame_err;
    logic [7:0] ok_cnt;
    logic [7:0] err_cnt;

    uart_rx_deframer #(
        .FIFO_CNT_W(5), .SYNC_BYTE(8'h7E), .MAX_LEN(64), .TIMEOUT(100), .TO_W(16)
    ) dut (
        .clk(clk), .rst(rst), .rf_count(rf_count), .rdr(rdr), .rf_pop(rf_pop),
        .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready), .m_last(m_last),
        .m_dest(m_dest), .frame_done(frame_done), .frame_err(frame_err),
        .ok_cnt(ok_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    logic [7:0] fifo_q[$];
    logic [7:0] beat_data[$];
    logic       beat_last[$];
    logic [7:0] beat_dest[$];
    logic [1:0] done_err[$];
    int         done_cyc[$];
    logic       done_mv[$];
    int   cyc = 0, last_pop_cyc = 0, consec = 0;
    logic prev_pop = 1'b0;
    logic rst_next = 1'b1;
    logic stall_mode = 1'b0;
    int   stall_cnt = 0, stall_bad_data = 0, stall_pops = 0, stall_bad_cnt = 0;
    int   n_checks = 0, n_errors = 0;
    logic [7:0] exp_pl [3];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic one_cycle();
        @(negedge clk);
        rst      = rst_next;
        rf_count = (fifo_q.size() > 31) ? 5'd31 : 5'(fifo_q.size());
        rdr      = (fifo_q.size() > 0) ? fifo_q[0] : 8'h00;
        m_ready  = !(stall_mode && (stall_cnt < 10));
        #1;
        cyc++;
        if (stall_mode && m_valid && !m_ready) begin
            stall_cnt++;
            if (m_data !== 8'h11) stall_bad_data++;
            if (rf_pop) stall_pops++;
            if (rf_count !== 5'd3) stall_bad_cnt++;
        end
        if (rf_pop) begin
            if (prev_pop) consec++;
            last_pop_cyc = cyc;
            if (fifo_q.size() > 0) void'(fifo_q.pop_front());
        end
        prev_pop = rf_pop;
        if (m_valid && m_ready) begin
            beat_data.push_back(m_data);
            beat_last.push_back(m_last);
            beat_dest.push_back(m_dest);
        end
        if (frame_done) begin
            done_err.push_back(frame_err);
            done_cyc.push_back(cyc);
            done_mv.push_back(m_valid);
        end
    endtask

    task automatic clear_obs();
        beat_data.delete(); beat_last.delete(); beat_dest.delete();
        done_err.delete(); done_cyc.delete(); done_mv.delete();
    endtask

    task automatic push_good(input logic [7:0] csum);
        fifo_q.push_back(8'h7E); fifo_q.push_back(8'h05); fifo_q.push_back(8'h03);
        fifo_q.push_back(8'h11); fifo_q.push_back(8'h22); fifo_q.push_back(8'h33);
        fifo_q.push_back(csum);
    endtask

    task automatic run_until_done(input string tag, input int n_done, input int budget);
        int k;
        k = 0;
        while ((done_err.size() < n_done) && (k < budget)) begin
            one_cycle();
            k++;
        end
        chk({tag, "_done_seen"}, done_err.size(), n_done);
        repeat (4) one_cycle();
    endtask

    // Payload 11 22 33, DEST 05, m_last only on the third beat
    task automatic check_beats(input string tag);
        chk({tag, "_beats"}, beat_data.size(), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < beat_data.size()) begin
                chk($sformatf("%s_data%0d", tag, i), beat_data[i], exp_pl[i]);
                chk($sformatf("%s_last%0d", tag, i), beat_last[i], (i == 2) ? 32'd1 : 32'd0);
                chk($sformatf("%s_dest%0d", tag, i), beat_dest[i], 32'h05);
            end
        end
    endtask

    task automatic check_done(input string tag, input int idx, input logic [1:0] exp_err);
        if (idx < done_err.size()) begin
            chk($sformatf("%s_err%0d", tag, idx), done_err[idx], exp_err);
            chk($sformatf("%s_mv%0d", tag, idx), done_mv[idx], 32'd0);
        end else begin
            chk($sformatf("%s_missing%0d", tag, idx), done_err.size(), idx + 1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=expired exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_pl[0] = 8'h11; exp_pl[1] = 8'h22; exp_pl[2] = 8'h33;
        repeat (3) one_cycle();
        rst_next = 1'b0;
        one_cycle();
        chk("rst_valid", m_valid, 32'd0);
        chk("rst_bytes", {m_data, m_dest, ok_cnt, err_cnt}, 32'd0);
        chk("rst_flags", {m_last, frame_done, frame_err, rf_pop}, 32'd0);

        // Good frame
        clear_obs(); push_good(8'h92);
        run_until_done("good", 1, 80);
        check_beats("good"); check_done("good", 0, 2'b00);
        chk("good_ok", ok_cnt, 32'd1); chk("good_errc", err_cnt, 32'd0);
        chk("good_consec", consec, 32'd0);

        // Bad checksum
        clear_obs(); push_good(8'h93);
        run_until_done("badcs", 1, 80);
        check_beats("badcs"); check_done("badcs", 0, 2'b01);
        chk("badcs_ok", ok_cnt, 32'd1); chk("badcs_errc", err_cnt, 32'd1);

        // Garbage, LEN=0, good frame, LEN=65
        clear_obs();
        fifo_q.push_back(8'h00); fifo_q.push_back(8'hFF); fifo_q.push_back(8'h7E);
        fifo_q.push_back(8'h05); fifo_q.push_back(8'h00);
        push_good(8'h92);
        fifo_q.push_back(8'h7E); fifo_q.push_back(8'h05); fifo_q.push_back(8'h41);
        run_until_done("len", 3, 200);
        check_done("len", 0, 2'b10); check_done("len", 1, 2'b00); check_done("len", 2, 2'b10);
        check_beats("len");
        chk("len_fifo_empty", fifo_q.size(), 32'd0);
        chk("len_ok", ok_cnt, 32'd2); chk("len_errc", err_cnt, 32'd3);

        // Backpressure: first beat held for 10 cycles
        clear_obs();
        stall_mode = 1'b1; stall_cnt = 0;
        push_good(8'h92);
        run_until_done("bp", 1, 150);
        stall_mode = 1'b0;
        chk("bp_stall_cycles", stall_cnt, 32'd10);
        chk("bp_stall_data", stall_bad_data, 32'd0);
        chk("bp_stall_pops", stall_pops, 32'd0);
        chk("bp_stall_count", stall_bad_cnt, 32'd0);
        check_beats("bp"); check_done("bp", 0, 2'b00);
        chk("bp_ok", ok_cnt, 32'd3);

        // Timeout after 11, then recovery
        clear_obs();
        fifo_q.push_back(8'h7E); fifo_q.push_back(8'h05);
        fifo_q.push_back(8'h03); fifo_q.push_back(8'h11);
        run_until_done("to", 1, 300);
        check_done("to", 0, 2'b11);
        if (done_cyc.size() > 0) chk("to_delta", done_cyc[0] - last_pop_cyc, 32'd100);
        chk("to_beats", beat_data.size(), 32'd1);
        chk("to_errc", err_cnt, 32'd4);
        clear_obs(); push_good(8'h92);
        run_until_done("to_rec", 1, 80);
        check_beats("to_rec"); check_done("to_rec", 0, 2'b00);
        chk("to_rec_ok", ok_cnt, 32'd4);

        // Reset during PAYLOAD
        clear_obs(); push_good(8'h92);
        for (int k = 0; (k < 40) && (beat_data.size() < 1); k++) one_cycle();
        chk("mrst_beat_seen", beat_data.size(), 32'd1);
        rst_next = 1'b1; one_cycle();
        rst_next = 1'b0; one_cycle();
        chk("mrst_valid", m_valid, 32'd0);
        chk("mrst_bytes", {m_data, m_dest, ok_cnt, err_cnt}, 32'd0);
        chk("mrst_flags", {m_last, frame_done, frame_err, rf_pop}, 32'd0);
        chk("mrst_fifo_kept", fifo_q.size(), 32'd3);
        clear_obs();
        repeat (20) one_cycle();
        chk("mrst_discard_fifo", fifo_q.size(), 32'd0);
        chk("mrst_discard_beats", beat_data.size(), 32'd0);
        chk("mrst_discard_done", done_err.size(), 32'd0);
        push_good(8'h92);
        run_until_done("mrst_rec", 1, 80);
        check_beats("mrst_rec"); check_done("mrst_rec", 0, 2'b00);
        chk("mrst_rec_ok", ok_cnt, 32'd1); chk("mrst_rec_errc", err_cnt, 32'd0);

        chk("no_consec_pops", consec, 32'd0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
